// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory responder for the multi-channel memory interface driven by the gpu
// memory controllers. Each channel runs its own small request FSM. All
// channels share one internal 2**ADDR_BITS-word array, and the array serves
// one access per cycle under round-robin arbitration. A host port preloads
// the array, and a preload takes priority over every channel.
//
// Optional feature (compile-time macro MEM_RESP_ERR_EN):
//   When defined, the module adds a sticky per-channel proto_error output.
//   It flags requester protocol violations. When undefined, neither the port
//   nor the checking logic exists.
//
// Ports
//   clk                in   clock, rising edge
//   reset              in   asynchronous, active-high
//   mem_read_valid     in   [NUM_CHANNELS]           read request per channel
//   mem_read_address   in   [ADDR_BITS] x NUM_CH     read address, held while valid
//   mem_read_ready     out  [NUM_CHANNELS]           one-cycle read acknowledge
//   mem_read_data      out  [DATA_BITS] x NUM_CH     read data, qualified by ready
//   mem_write_valid    in   [NUM_CHANNELS]           write request per channel
//   mem_write_address  in   [ADDR_BITS] x NUM_CH     write address, held while valid
//   mem_write_data     in   [DATA_BITS] x NUM_CH     write data, held while valid
//   mem_write_ready    out  [NUM_CHANNELS]           one-cycle write acknowledge
//   init_write_enable  in   host preload strobe
//   init_address       in   host preload address
//   init_data          in   host preload data
//   busy               out  any channel not IDLE
//   proto_error        out  [NUM_CHANNELS] sticky protocol error (MEM_RESP_ERR_EN only)
//   state_dbg          out  [2*NUM_CHANNELS] per-channel FSM state, 2 bits per channel
//
// Handshake: the requester raises valid and holds address/data stable until
// ready. The responder pulses ready for exactly one cycle. It then waits for
// valid to fall before it accepts another request on that channel. If valid
// falls early, the access still completes and ready still pulses once.
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] mem_read_valid,
  input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_read_ready,
  output logic [DATA_BITS-1:0]    mem_read_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] mem_write_valid,
  input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]    mem_write_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_write_ready,
  input  logic                    init_write_enable,
  input  logic [ADDR_BITS-1:0]    init_address,
  input  logic [DATA_BITS-1:0]    init_data,
  output logic                    busy,
`ifdef MEM_RESP_ERR_EN
  output logic [NUM_CHANNELS-1:0] proto_error,
`endif
  output logic [2*NUM_CHANNELS-1:0] state_dbg
);

  localparam int         CH_BITS  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                  state    [NUM_CHANNELS];
  logic [3:0]              cnt      [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    lat_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    lat_data [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] op_write;
  logic [CH_BITS-1:0]      rr_ptr;

  logic [DATA_BITS-1:0]    mem [DEPTH];

  logic [NUM_CHANNELS-1:0] req;
  logic [NUM_CHANNELS-1:0] grant;
  logic                    gnt_any;
  logic [CH_BITS-1:0]      gnt_idx;
  logic [CH_BITS-1:0]      cand;
  logic [CH_BITS-1:0]      rr_next;
  logic [DATA_BITS-1:0]    rd_word;

  // A channel asks for the array once its wait count has run out.
  always_comb begin
    req = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      req[c] = (state[c] == S_WAIT) && (cnt[c] == 4'd0);
    end
  end

  // Round-robin search starts at rr_ptr. A host preload in the same cycle
  // blocks every grant, because the array port is busy with the preload.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cand = CH_BITS'((int'(rr_ptr) + i) % NUM_CHANNELS);
      if (!gnt_any && !init_write_enable && req[cand]) begin
        gnt_any     = 1'b1;
        gnt_idx     = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  assign rr_next = CH_BITS'((int'(gnt_idx) + 1) % NUM_CHANNELS);

  // Single read port: only the granted channel's address is looked up.
  assign rd_word = mem[lat_addr[gnt_idx]];

  // The array has no reset, so its contents survive reset. The extra reset
  // term blocks a channel write when reset and a clock edge coincide.
  always_ff @(posedge clk) begin
    if (init_write_enable) begin
      mem[init_address] <= init_data;
    end else if (gnt_any && op_write[gnt_idx] && !reset) begin
      mem[lat_addr[gnt_idx]] <= lat_data[gnt_idx];
    end
  end

  // Per-channel request FSMs with registered ready and read-data outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr          <= '0;
      op_write        <= '0;
      mem_read_ready  <= '0;
      mem_write_ready <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state[c]         <= S_IDLE;
        cnt[c]           <= 4'd0;
        lat_addr[c]      <= '0;
        lat_data[c]      <= '0;
        mem_read_data[c] <= '0;
      end
    end else begin
      if (gnt_any) begin
        rr_ptr <= rr_next;
      end
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (state[c])
          S_IDLE: begin
            mem_read_ready[c]  <= 1'b0;
            mem_write_ready[c] <= 1'b0;
            // A write wins over a simultaneous read. The read is still
            // pending when this channel next returns to IDLE.
            if ((WRITE_ENABLE != 0) && mem_write_valid[c]) begin
              op_write[c] <= 1'b1;
              lat_addr[c] <= mem_write_address[c];
              lat_data[c] <= mem_write_data[c];
              cnt[c]      <= LAT_INIT;
              state[c]    <= S_WAIT;
            end else if (mem_read_valid[c]) begin
              op_write[c] <= 1'b0;
              lat_addr[c] <= mem_read_address[c];
              cnt[c]      <= LAT_INIT;
              state[c]    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (cnt[c] != 4'd0) begin
              cnt[c] <= cnt[c] - 4'd1;
            end else if (grant[c]) begin
              if (op_write[c]) begin
                mem_write_ready[c] <= 1'b1;
              end else begin
                mem_read_ready[c] <= 1'b1;
                mem_read_data[c]  <= rd_word;
              end
              state[c] <= S_RESPOND;
            end
          end
          S_RESPOND: begin
            mem_read_ready[c]  <= 1'b0;
            mem_write_ready[c] <= 1'b0;
            state[c]           <= S_RELEASE;
          end
          S_RELEASE: begin
            // Hold here until the requester retracts the latched op's valid.
            // Without this, a held valid would look like a fresh request.
            if (op_write[c] ? !mem_write_valid[c] : !mem_read_valid[c]) begin
              state[c] <= S_IDLE;
            end
          end
          default: begin
            state[c] <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    busy      = 1'b0;
    state_dbg = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_dbg[2*c +: 2] = state[c];
      if (state[c] != S_IDLE) begin
        busy = 1'b1;
      end
    end
  end

`ifdef MEM_RESP_ERR_EN
  // Sticky protocol-violation flags. Only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_error <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (state[c] == S_WAIT) begin
          if (op_write[c]) begin
            if (!mem_write_valid[c] ||
                (mem_write_address[c] != lat_addr[c]) ||
                (mem_write_data[c] != lat_data[c])) begin
              proto_error[c] <= 1'b1;
            end
          end else begin
            if (!mem_read_valid[c] || (mem_read_address[c] != lat_addr[c])) begin
              proto_error[c] <= 1'b1;
            end
          end
        end
        if ((WRITE_ENABLE == 0) && mem_write_valid[c]) begin
          proto_error[c] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
